tile_addr_gen: RTL and testbench

TILE_ADDR_GEN -- requirements
Module: tile_addr_gen

---
 rtl/tile_addr_gen.sv | 212 +++++++++++++++++++++
 tb/tb_tile_addr_gen.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/tile_addr_gen.sv
// Streams per-lane element addresses for a tiled sweep (rep, tile row, k); one beat per cycle, outputs registered.
// Beats are held stable while out_ready is low; loop state only advances when a beat is accepted.
module tile_addr_gen #(
  parameter int LANES  = 8,
  parameter int ADDR_W = 18,
  parameter int DIM_W  = 12,
  parameter int REP_W  = 6
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    abort,
  input  logic [ADDR_W-1:0]       cfg_base,
  input  logic [DIM_W-1:0]        cfg_rows,
  input  logic [DIM_W-1:0]        cfg_cols,
  input  logic [DIM_W-1:0]        cfg_ld,
  input  logic [REP_W-1:0]        cfg_repeat,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [LANES*ADDR_W-1:0] out_addr,
  output logic [LANES-1:0]        out_lane_valid,
  output logic [DIM_W-1:0]        out_tile_row,
  output logic [DIM_W-1:0]        out_k,
  output logic                    out_last_k,
  output logic                    out_last,
  output logic                    busy,
  output logic                    done
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t state;

  logic [ADDR_W-1:0] base_q;
  logic [DIM_W-1:0]  rows_q;
  logic [DIM_W-1:0]  cols_q;
  logic [DIM_W-1:0]  ld_q;
  logic [REP_W-1:0]  rep_q;

  // Loop state for the beat currently on the outputs.
  logic [ADDR_W-1:0] row_base;
  logic [DIM_W-1:0]  rows_rem;
  logic [REP_W-1:0]  rep_cnt;

  logic              idle;
  logic              fire;
  logic              zero_cfg;
  logic              accept;
  logic              load;

  logic [DIM_W-1:0]  cols_s;
  logic [DIM_W-1:0]  ld_s;
  logic [REP_W-1:0]  rep_s;

  logic [ADDR_W-1:0] ld_ext;
  logic [ADDR_W-1:0] acc;
  logic [ADDR_W-1:0] tile_step;
  logic [ADDR_W-1:0] lane_off [LANES];

  logic [DIM_W-1:0]  nk;
  logic [DIM_W-1:0]  ntr;
  logic [ADDR_W-1:0] nrb;
  logic [DIM_W-1:0]  nrr;
  logic [REP_W-1:0]  nrep;

  logic [LANES*ADDR_W-1:0] n_addr;
  logic [LANES-1:0]        n_lane_valid;
  logic                    n_last_k;
  logic                    n_last;

  assign idle     = (state == S_IDLE);
  assign fire     = out_valid && out_ready;
  assign zero_cfg = (cfg_rows == '0) || (cfg_cols == '0) || (cfg_repeat == '0);
  assign accept   = idle && start && !abort;
  assign load     = (accept && !zero_cfg) ||
                    ((state == S_RUN) && !abort && fire && !out_last);

  // The first beat is computed straight from the cfg inputs on the accept cycle.
  assign cols_s = idle ? cfg_cols   : cols_q;
  assign ld_s   = idle ? cfg_ld     : ld_q;
  assign rep_s  = idle ? cfg_repeat : rep_q;

  // Lane offsets i*ld by running sum; the sum after the last lane is the tile-row step.
  always_comb begin
    ld_ext = ADDR_W'(ld_s);
    acc    = '0;
    for (int i = 0; i < LANES; i++) begin
      lane_off[i] = acc;
      acc         = acc + ld_ext;
    end
    tile_step = acc;
  end

  always_comb begin
    nk   = '0;
    ntr  = '0;
    nrb  = cfg_base;
    nrr  = cfg_rows;
    nrep = '0;
    if (!idle) begin
      nk   = out_k + DIM_W'(1);
      ntr  = out_tile_row;
      nrb  = row_base;
      nrr  = rows_rem;
      nrep = rep_cnt;
      if (out_last_k) begin
        nk = '0;
        if (rows_rem <= DIM_W'(LANES)) begin
          ntr  = '0;
          nrb  = base_q;
          nrr  = rows_q;
          nrep = rep_cnt + REP_W'(1);
        end else begin
          ntr = out_tile_row + DIM_W'(1);
          nrb = row_base + tile_step;
          nrr = rows_rem - DIM_W'(LANES);
        end
      end
    end
  end

  always_comb begin
    n_last_k = (nk == cols_s - DIM_W'(1));
    n_last   = n_last_k && (nrr <= DIM_W'(LANES)) && (nrep == rep_s - REP_W'(1));
    for (int i = 0; i < LANES; i++) begin
      n_addr[i*ADDR_W +: ADDR_W] = nrb + lane_off[i] + ADDR_W'(nk);
      n_lane_valid[i]            = (nrr > DIM_W'(i));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      base_q         <= '0;
      rows_q         <= '0;
      cols_q         <= '0;
      ld_q           <= '0;
      rep_q          <= '0;
      row_base       <= '0;
      rows_rem       <= '0;
      rep_cnt        <= '0;
      out_addr       <= '0;
      out_lane_valid <= '0;
      out_tile_row   <= '0;
      out_k          <= '0;
      out_last_k     <= 1'b0;
      out_last       <= 1'b0;
    end else begin
      if (accept) begin
        base_q <= cfg_base;
        rows_q <= cfg_rows;
        cols_q <= cfg_cols;
        ld_q   <= cfg_ld;
        rep_q  <= cfg_repeat;
      end
      if (load) begin
        row_base       <= nrb;
        rows_rem       <= nrr;
        rep_cnt        <= nrep;
        out_addr       <= n_addr;
        out_lane_valid <= n_lane_valid;
        out_tile_row   <= ntr;
        out_k          <= nk;
        out_last_k     <= n_last_k;
        out_last       <= n_last;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (accept) begin
            if (zero_cfg) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              state     <= S_RUN;
              out_valid <= 1'b1;
              busy      <= 1'b1;
            end
          end
        end
        S_RUN: begin
          if (abort) begin
            state     <= S_IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
          end else if (fire && out_last) begin
            state     <= S_DONE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b1;
          end
        end
        default: begin
          state     <= S_IDLE;
          out_valid <= 1'b0;
          busy      <= 1'b0;
          done      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tile_addr_gen.sv
// Randomized bench for tile_addr_gen: expected beats come from a nested-loop reference model.
module tb_tile_addr_gen;
  localparam int LANES  = 8;
  localparam int ADDR_W = 18;
  localparam int DIM_W  = 12;
  localparam int REP_W  = 6;
  localparam int CW     = LANES*ADDR_W;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    start;
  logic                    abort;
  logic [ADDR_W-1:0]       cfg_base;
  logic [DIM_W-1:0]        cfg_rows;
  logic [DIM_W-1:0]        cfg_cols;
  logic [DIM_W-1:0]        cfg_ld;
  logic [REP_W-1:0]        cfg_repeat;
  logic                    out_valid;
  logic                    out_ready;
  logic [LANES*ADDR_W-1:0] out_addr;
  logic [LANES-1:0]        out_lane_valid;
  logic [DIM_W-1:0]        out_tile_row;
  logic [DIM_W-1:0]        out_k;
  logic                    out_last_k;
  logic                    out_last;
  logic                    busy;
  logic                    done;

  tile_addr_gen #(.LANES(LANES), .ADDR_W(ADDR_W), .DIM_W(DIM_W), .REP_W(REP_W)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .cfg_base(cfg_base), .cfg_rows(cfg_rows), .cfg_cols(cfg_cols),
    .cfg_ld(cfg_ld), .cfg_repeat(cfg_repeat),
    .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr),
    .out_lane_valid(out_lane_valid), .out_tile_row(out_tile_row), .out_k(out_k),
    .out_last_k(out_last_k), .out_last(out_last), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [CW-1:0]    addr;
    logic [LANES-1:0] lv;
    int               tr;
    int               k;
    bit               lk;
    bit               last;
  } beat_t;

  beat_t exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: plain nested loops over rep, tile row and k with direct multiplication.
  task automatic build_model(input int base, input int m, input int kk, input int ld, input int r);
    int tiles;
    beat_t b;
    exp_q.delete();
    tiles = (m + LANES - 1) / LANES;
    for (int rp = 0; rp < r; rp++)
      for (int tr = 0; tr < tiles; tr++)
        for (int k = 0; k < kk; k++) begin
          logic [ADDR_W-1:0] a;
          for (int i = 0; i < LANES; i++) begin
            int row;
            row = tr*LANES + i;
            a = ADDR_W'(base + row*ld + k);
            b.addr[i*ADDR_W +: ADDR_W] = a;
            b.lv[i] = (row < m);
          end
          b.tr   = tr;
          b.k    = k;
          b.lk   = (k == kk - 1);
          b.last = (rp == r - 1) && (tr == tiles - 1) && (k == kk - 1);
          exp_q.push_back(b);
        end
  endtask

  task automatic junk_cfg();
    cfg_base   = ADDR_W'($urandom);
    cfg_rows   = DIM_W'($urandom);
    cfg_cols   = DIM_W'($urandom);
    cfg_ld     = DIM_W'($urandom);
    cfg_repeat = REP_W'($urandom);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_valid"}, out_valid, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_addr"}, out_addr, 0);
    chk({tag, "_lv"}, out_lane_valid, 0);
    chk({tag, "_tr"}, out_tile_row, 0);
    chk({tag, "_k"}, out_k, 0);
    chk({tag, "_lastk"}, out_last_k, 0);
    chk({tag, "_last"}, out_last, 0);
  endtask

  task automatic run(input int base, input int m, input int kk, input int ld, input int r,
                     input int ready_pct, input int stall_beat, input int stall_len,
                     input int abort_at, input int rst_at);
    int total, idx, cyc, stall_cnt;
    bit fire;
    build_model(base, m, kk, ld, r);
    total = exp_q.size();
    cfg_base = ADDR_W'(base); cfg_rows = DIM_W'(m); cfg_cols = DIM_W'(kk);
    cfg_ld = DIM_W'(ld); cfg_repeat = REP_W'(r);
    start = 1'b1; abort = 1'b0; out_ready = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    junk_cfg();
    if (total == 0) begin
      chk("zero_valid", out_valid, 0);
      chk("zero_done", done, 1);
      chk("zero_busy", busy, 0);
      @(posedge clk); #1;
      chk("zero_done_drop", done, 0);
      chk("zero_valid2", out_valid, 0);
      return;
    end
    chk("run_busy", busy, 1);
    idx = 0; cyc = 0; stall_cnt = 0;
    forever begin
      if (cyc > 4000) begin
        chk("timeout", 1, 0);
        return;
      end
      if (idx >= total) begin
        start = 1'b0;
        chk("end_valid", out_valid, 0);
        chk("end_done", done, 1);
        chk("end_busy", busy, 0);
        if (ready_pct == 100 && stall_len == 0) chk("cycles", cyc, total);
        @(posedge clk); #1;
        chk("done_pulse", done, 0);
        chk("idle_valid", out_valid, 0);
        return;
      end
      chk("valid", out_valid, 1);
      chk("done_early", done, 0);
      chk("busy", busy, 1);
      chk("addr", out_addr, exp_q[idx].addr);
      chk("lane_valid", out_lane_valid, exp_q[idx].lv);
      chk("tile_row", out_tile_row, exp_q[idx].tr);
      chk("k", out_k, exp_q[idx].k);
      chk("last_k", out_last_k, exp_q[idx].lk);
      chk("last", out_last, exp_q[idx].last);
      if (idx == abort_at) begin
        abort = 1'b1; out_ready = 1'b1; start = 1'b0;
        @(posedge clk); #1;
        abort = 1'b0;
        chk("abort_valid", out_valid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        @(posedge clk); #1;
        chk("abort_done2", done, 0);
        chk("abort_valid2", out_valid, 0);
        return;
      end
      if (idx == rst_at) begin
        rst = 1'b1; out_ready = 1'b1; start = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        chk_all_zero("midrst");
        @(posedge clk); #1;
        chk("midrst_done2", done, 0);
        return;
      end
      if (idx == stall_beat && stall_cnt < stall_len) begin
        out_ready = 1'b0;
        stall_cnt++;
      end else begin
        out_ready = ($urandom_range(99) < ready_pct);
      end
      start = 1'($urandom_range(1));
      junk_cfg();
      fire = out_ready;
      @(posedge clk); #1;
      cyc++;
      if (fire) idx++;
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; out_ready = 1'b0;
    junk_cfg();
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    rst = 1'b0;

    cfg_base = 18'h100; cfg_rows = 12'd20; cfg_cols = 12'd3; cfg_ld = 12'd32; cfg_repeat = 6'd1;
    start = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    chk("sa_valid", out_valid, 0);
    chk("sa_busy", busy, 0);
    @(posedge clk); #1;
    chk("sa_done", done, 0);

    run('h100, 20, 3, 32, 1, 100, -1, 0, -1, -1);
    run('h100, 20, 3, 32, 1, 100, 4, 4, -1, -1);
    run(0, 8, 2, 4, 3, 100, -1, 0, -1, -1);
    run('h100, 20, 0, 32, 1, 100, -1, 0, -1, -1);
    run('h100, 0, 3, 32, 1, 100, -1, 0, -1, -1);
    run('h100, 20, 3, 32, 0, 100, -1, 0, -1, -1);
    run('h3FFF0, 8, 1, 4, 1, 100, -1, 0, -1, -1);
    run('h100, 20, 3, 32, 1, 100, -1, 0, 3, -1);
    run('h100, 20, 3, 32, 1, 100, -1, 0, -1, 5);
    run('h100, 20, 3, 32, 1, 100, -1, 0, -1, -1);

    for (int t = 0; t < 25; t++) begin
      int m, kk, r, ld, pct;
      m   = ($urandom_range(9) == 0) ? 0 : $urandom_range(1, 40);
      kk  = $urandom_range(0, 6);
      r   = $urandom_range(0, 3);
      ld  = $urandom_range(0, 100);
      pct = $urandom_range(30, 100);
      run(int'($urandom_range(0, (1 << ADDR_W) - 1)), m, kk, ld, r, pct, -1, 0, -1, -1);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
